// File: rtl/rep_sub_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state
// encoding, default operand width and the saturated quotient value.
package rep_sub_divider_pkg;

  localparam int DEF_WIDTH = 16;

  // Quotient value reported when the counter saturates or on divide-by-zero
  localparam logic [DEF_WIDTH-1:0] QUOT_ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_SUB  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/rep_sub_divider_quot_counter.sv
// Quotient counter: WIDTH-bit up-counter with synchronous clear, increment
// enable and a saturation flag. It never wraps; increments at all-ones
// are dropped so the divider can use sat to terminate iteration.
module rep_sub_divider_quot_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over increment, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = &count_q;

endmodule

// File: rtl/rep_sub_divider.sv
// Sequential unsigned divider using repeated subtraction. Dividend and
// divisor arrive on consecutive cycles over the shared data_in bus after
// start; one subtraction is performed per cycle until remainder < divisor
// or the quotient counter saturates.
// Optional feature macro: DIVZ_DETECT_EN -- when defined, a zero divisor
// finishes immediately with err=1 and an all-ones quotient; when undefined
// err is tied low and a zero divisor runs until the quotient saturates.
module rep_sub_divider
  import rep_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_sat;
  logic             rem_lt_div;

  assign rem_lt_div = (rem_q < div_q);

  rep_sub_divider_quot_counter #(
    .WIDTH(WIDTH)
  ) u_quot_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(cnt_val),
    .sat  (cnt_sat)
  );

`ifdef DIVZ_DETECT_EN
  logic err_q;
  logic err_d;
  logic div_zero;

  assign div_zero = (div_q == '0);

  // Next-state and datapath control, with immediate exit on a zero divisor
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LDA;
      end
      ST_LDA: begin
        rem_d   = data_in;
        state_d = ST_LDB;
      end
      ST_LDB: begin
        div_d   = data_in;
        cnt_clr = 1'b1;
        err_d   = 1'b0;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        if (div_zero) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (rem_lt_div || cnt_sat) begin
          state_d = ST_DONE;
        end else begin
          rem_d   = rem_q - div_q;
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_LDA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // A flagged divide-by-zero reports an all-ones quotient; the counter
  // itself stays at zero in that case.
  assign quotient = err_q ? {WIDTH{1'b1}} : cnt_val;
  assign err      = err_q;
`else
  // Next-state and datapath control; a zero divisor subtracts zero until
  // the quotient counter saturates
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LDA;
      end
      ST_LDA: begin
        rem_d   = data_in;
        state_d = ST_LDB;
      end
      ST_LDB: begin
        div_d   = data_in;
        cnt_clr = 1'b1;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        if (rem_lt_div || cnt_sat) begin
          state_d = ST_DONE;
        end else begin
          rem_d   = rem_q - div_q;
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_LDA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign quotient = cnt_val;
  assign err      = 1'b0;
`endif

  // State, remainder and divisor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end

  assign remainder = rem_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rep_sub_divider.sv
// Self-checking bench for rep_sub_divider: a 16-bit instance for the main
// vectors and an 8-bit instance where saturation and zero-divisor runs are
// short. Optional feature macro: DIVZ_DETECT_EN changes the expectations.
module tb_rep_sub_divider;
  import rep_sub_divider_pkg::*;

  typedef struct {
    bit          sel8;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          lat;
  } vec_t;

`ifdef DIVZ_DETECT_EN
  localparam bit DIVZ = 1'b1;
`else
  localparam bit DIVZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start16 = 1'b0;
  logic [15:0] data16 = '0;
  logic [15:0] q16, r16;
  logic        done16, err16;
  logic        start8 = 1'b0;
  logic [7:0]  data8 = '0;
  logic [7:0]  q8, r8;
  logic        done8, err8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rep_sub_divider #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .data_in(data16),
    .quotient(q16), .remainder(r16), .done(done16), .err(err16)
  );

  rep_sub_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data8),
    .quotient(q8), .remainder(r8), .done(done8), .err(err8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel8, input logic st, input logic [15:0] d);
    if (sel8) begin
      start8 = st;
      data8  = d[7:0];
    end else begin
      start16 = st;
      data16  = d;
    end
  endtask

  function automatic logic get_done(input bit sel8);
    return sel8 ? done8 : done16;
  endfunction

  function automatic logic [15:0] get_q(input bit sel8);
    return sel8 ? {8'h00, q8} : q16;
  endfunction

  function automatic logic [15:0] get_r(input bit sel8);
    return sel8 ? {8'h00, r8} : r16;
  endfunction

  function automatic logic get_err(input bit sel8);
    return sel8 ? err8 : err16;
  endfunction

  // Called right after the edge that samples the divisor (edges = 2);
  // returns the edge count, relative to the start edge, at which done rose.
  task automatic wait_done(input bit sel8, inout int edges);
    @(negedge clk);
    while (!get_done(sel8) && edges < 70000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (edges >= 70000) chk("timeout", 1, 0);
  endtask

  task automatic do_div(input vec_t v, input string tag);
    int edges;
    @(negedge clk);
    drive(v.sel8, 1'b1, 16'h0);
    @(posedge clk);                       // edge N accepts start
    @(negedge clk);
    drive(v.sel8, 1'b0, v.a);
    chk({tag, ".busy"}, get_done(v.sel8), 0);
    @(posedge clk);                       // edge N+1: dividend
    @(negedge clk);
    drive(v.sel8, 1'b0, v.b);
    @(posedge clk);                       // edge N+2: divisor
    edges = 2;
    wait_done(v.sel8, edges);
    drive(v.sel8, 1'b0, 16'h0);
    chk({tag, ".lat"}, edges, v.lat);
    chk({tag, ".q"},   get_q(v.sel8), v.q);
    chk({tag, ".r"},   get_r(v.sel8), v.r);
    chk({tag, ".err"}, get_err(v.sel8), v.err);
    $display("xact %s w%0d: a=%0d b=%0d -> q=%0d r=%0d err=%0b lat=%0d", tag,
             v.sel8 ? 8 : 16, v.a, v.b, get_q(v.sel8), get_r(v.sel8),
             get_err(v.sel8), edges);
  endtask

  // Reference: plain integer division, with the zero-divisor and
  // saturation rules applied at the operand width.
  function automatic vec_t model(input bit sel8, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    int   maxq;
    maxq   = sel8 ? 255 : 65535;
    v.sel8 = sel8;
    v.a    = a;
    v.b    = b;
    if (b == 0) begin
      v.q   = 16'(maxq);
      v.r   = a;
      v.err = DIVZ;
      v.lat = DIVZ ? 3 : maxq + 3;
    end else begin
      v.q   = a / b;
      v.r   = a % b;
      v.err = 1'b0;
      v.lat = int'(a / b) + 3;
    end
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int   edges;
    vec_t v;
    logic [15:0] ra, rb;
    int   rq;

    tbl.push_back('{1'b0, 16'd17,    16'd5, 16'd3,     16'd2, 1'b0, 6});
    tbl.push_back('{1'b0, 16'd3,     16'd7, 16'd0,     16'd3, 1'b0, 3});
    tbl.push_back('{1'b0, 16'd0,     16'd5, 16'd0,     16'd0, 1'b0, 3});
    tbl.push_back('{1'b0, 16'd5,     16'd5, 16'd1,     16'd0, 1'b0, 4});
    tbl.push_back('{1'b0, 16'd65535, 16'd1, QUOT_ALL_ONES, 16'd0, 1'b0, 65538});
    tbl.push_back('{1'b1, 16'd200,   16'd7, 16'd28,    16'd4, 1'b0, 31});
    tbl.push_back('{1'b1, 16'd255,   16'd1, 16'd255,   16'd0, 1'b0, 258});
    tbl.push_back('{1'b1, 16'd100,   16'd0, 16'd255,   16'd100, DIVZ, DIVZ ? 3 : 258});
`ifdef DIVZ_DETECT_EN
    tbl.push_back('{1'b0, 16'd100,   16'd0, QUOT_ALL_ONES, 16'd100, 1'b1, 3});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.done", done16, 0);
    chk("rst.q",    q16, 0);
    chk("rst.r",    r16, 0);
    chk("rst.err",  err16, 0);
    chk("rst.done8", done8, 0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      do_div(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset in the middle of 1000 / 3
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd1000);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd3);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid.q", q16, 10);
    chk("mid.r", r16, 970);
    chk("mid.done", done16, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort.q",    q16, 0);
    chk("abort.r",    r16, 0);
    chk("abort.done", done16, 0);
    chk("abort.err",  err16, 0);
    $display("xact abort: reset during 1000/3 after 10 subtractions");
    do_div('{1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 6}, "post_rst");

    // Back-to-back with start held high: 20/4 then 21/4
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd20);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'd4);
    @(posedge clk);
    edges = 2;
    wait_done(1'b0, edges);
    chk("b2b0.lat", edges, 8);
    chk("b2b0.q",   q16, 5);
    chk("b2b0.r",   r16, 0);
    $display("xact b2b0: a=20 b=4 -> q=%0d r=%0d lat=%0d", q16, r16, edges);
    @(posedge clk);                       // DONE accepts held start
    @(negedge clk);
    chk("b2b.drop", done16, 0);
    drive(1'b0, 1'b0, 16'd21);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'd4);
    @(posedge clk);
    edges = 2;
    wait_done(1'b0, edges);
    chk("b2b1.lat", edges, 8);
    chk("b2b1.q",   q16, 5);
    chk("b2b1.r",   r16, 1);
    $display("xact b2b1: a=21 b=4 -> q=%0d r=%0d lat=%0d", q16, r16, edges);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.hold", done16, 1);

    // Random 16-bit operands with bounded quotients
    for (int i = 0; i < 20; i++) begin
      rb = 16'($urandom_range(1, 1000));
      rq = int'($urandom_range(0, 40));
      ra = 16'(int'(rb) * rq + int'($urandom_range(0, int'(rb) - 1)));
      v  = model(1'b0, ra, rb);
      do_div(v, $sformatf("rnd16_%0d", i));
    end

    // Random 8-bit operands, zero divisors included
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      v  = model(1'b1, ra, rb);
      do_div(v, $sformatf("rnd8_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
